// File: rtl/brick_memory.sv
// Purpose : brick-grid health store with a fill-on-reset init sweep, a registered lookup
//           port, write-only-downwards updates and a 2-entry queue of destroyed bricks.
// Latency : lookups return 1 cycle after memx/memy. Writes land on the same edge and
//           are write-first visible. Erase entries appear the cycle after the destroying write.
// Backpressure: the erase queue holds its head until erase_valid && erase_ack. A push into
//           a full queue is dropped and latches erase_ovf until reset.
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   memx, memy              pixel address for lookup and write
//   game_write, game_health write strobe and new health (accepted only if lower)
//   brickx, bricky, health  registered lookup result (aligned cell origin, cell health)
//   ready                   init sweep finished, lookups valid
//   bricks_left, all_clear  live-cell count, and "ready with nothing left"
//   erase_valid/x/y/ack     destroyed-brick notification queue to the renderer
//   erase_ovf               sticky: an erase notification was lost
module brick_memory #(
  parameter int BRICKX      = 20,
  parameter int BRICKY      = 10,
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int INIT_HEALTH = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] memx,
  input  logic [9:0] memy,
  input  logic       game_write,
  input  logic [1:0] game_health,
  output logic [9:0] brickx,
  output logic [9:0] bricky,
  output logic [1:0] health,
  output logic       ready,
  output logic [5:0] bricks_left,
  output logic       all_clear,
  output logic       erase_valid,
  output logic [9:0] erase_x,
  output logic [9:0] erase_y,
  input  logic       erase_ack,
  output logic       erase_ovf
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDXW  = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [9:0] GRID_W = 10'(COLS * BRICKX);
  localparam logic [9:0] GRID_H = 10'(ROWS * BRICKY);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CELLS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] init_idx_q, init_idx_d;
  logic [1:0]      cells_q [CELLS];
  logic [1:0]      cells_d [CELLS];
  logic [9:0]      brickx_q, brickx_d;
  logic [9:0]      bricky_q, bricky_d;
  logic [1:0]      health_q, health_d;
  logic [5:0]      bricks_left_q, bricks_left_d;
  // Erase queue: slot 0 is always the head, slot 1 shifts down on a pop.
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [9:0]      fx_q [2];
  logic [9:0]      fx_d [2];
  logic [9:0]      fy_q [2];
  logic [9:0]      fy_d [2];
  logic            ovf_q, ovf_d;

  // Address decode (unsigned 10-bit, truncating division by constants).
  logic [9:0]      col_full, row_full;
  logic [9:0]      align_x, align_y;
  logic            in_grid;
  logic [IDXW-1:0] cell_idx;
  logic [1:0]      cur_cell;
  logic            run;
  logic            wr_accept;
  logic            destroy;
  logic            pop;
  logic [1:0]      cnt_after_pop;

  always_comb begin
    col_full = memx / 10'(BRICKX);
    row_full = memy / 10'(BRICKY);
    align_x  = col_full * 10'(BRICKX);
    align_y  = row_full * 10'(BRICKY);
    in_grid  = (memx < GRID_W) && (memy < GRID_H);
    // Index aliases for out-of-grid addresses; every use is gated by in_grid.
    cell_idx = IDXW'(int'(row_full) * COLS + int'(col_full));
    cur_cell = in_grid ? cells_q[cell_idx] : 2'd0;
    run      = (state_q == S_RUN);
    // Health may only go down, so a zero write always hits a live cell.
    wr_accept = run && game_write && in_grid && (game_health < cur_cell);
    destroy   = wr_accept && (game_health == 2'd0);
  end

  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    cells_d       = cells_q;
    brickx_d      = brickx_q;
    bricky_d      = bricky_q;
    health_d      = health_q;
    bricks_left_d = bricks_left_q;
    fifo_cnt_d    = fifo_cnt_q;
    fx_d          = fx_q;
    fy_d          = fy_q;
    ovf_d         = ovf_q;
    pop           = 1'b0;
    cnt_after_pop = fifo_cnt_q;

    case (state_q)
      S_INIT: begin
        cells_d[init_idx_q] = 2'(INIT_HEALTH);
        if (init_idx_q == LAST_IDX) begin
          state_d       = S_RUN;
          init_idx_d    = '0;
          bricks_left_d = 6'(CELLS);
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      S_RUN: begin
        brickx_d = align_x;
        bricky_d = align_y;
        // Lookup and write share one address, so write-first is just a bypass.
        health_d = wr_accept ? game_health : cur_cell;
        if (wr_accept) begin
          cells_d[cell_idx] = game_health;
        end
        if (destroy && (bricks_left_q != 6'd0)) begin
          bricks_left_d = bricks_left_q - 6'd1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Erase queue; a same-edge pop frees a slot for the push.
    pop = (fifo_cnt_q != 2'd0) && erase_ack;
    if (pop) begin
      fx_d[0]       = fx_q[1];
      fy_d[0]       = fy_q[1];
      cnt_after_pop = fifo_cnt_q - 2'd1;
    end
    fifo_cnt_d = cnt_after_pop;
    if (destroy) begin
      if (cnt_after_pop < 2'd2) begin
        fx_d[cnt_after_pop[0]] = align_x;
        fy_d[cnt_after_pop[0]] = align_y;
        fifo_cnt_d             = cnt_after_pop + 2'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_INIT;
      init_idx_q    <= '0;
      for (int i = 0; i < CELLS; i++) begin
        cells_q[i] <= '0;
      end
      brickx_q      <= '0;
      bricky_q      <= '0;
      health_q      <= '0;
      bricks_left_q <= '0;
      fifo_cnt_q    <= '0;
      fx_q[0]       <= '0;
      fx_q[1]       <= '0;
      fy_q[0]       <= '0;
      fy_q[1]       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      cells_q       <= cells_d;
      brickx_q      <= brickx_d;
      bricky_q      <= bricky_d;
      health_q      <= health_d;
      bricks_left_q <= bricks_left_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fx_q          <= fx_d;
      fy_q          <= fy_d;
      ovf_q         <= ovf_d;
    end
  end

  assign brickx      = brickx_q;
  assign bricky      = bricky_q;
  assign health      = health_q;
  assign ready       = (state_q == S_RUN);
  assign bricks_left = bricks_left_q;
  assign all_clear   = (state_q == S_RUN) && (bricks_left_q == 6'd0);
  assign erase_valid = (fifo_cnt_q != 2'd0);
  assign erase_x     = fx_q[0];
  assign erase_y     = fy_q[0];
  assign erase_ovf   = ovf_q;

endmodule

// File: tb/tb_brick_memory.sv
// Directed bench for brick_memory with default parameters (20x10 bricks, 8x4 grid, health 3).
module tb_brick_memory;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [9:0] memx = '0;
  logic [9:0] memy = '0;
  logic       game_write = 1'b0;
  logic [1:0] game_health = '0;
  logic       erase_ack = 1'b0;
  logic [9:0] brickx, bricky, erase_x, erase_y;
  logic [1:0] health;
  logic       ready, all_clear, erase_valid, erase_ovf;
  logic [5:0] bricks_left;

  int errors = 0;
  int checks = 0;
  int ncyc;

  brick_memory dut (
    .clk         (clk),
    .resetn      (resetn),
    .memx        (memx),
    .memy        (memy),
    .game_write  (game_write),
    .game_health (game_health),
    .brickx      (brickx),
    .bricky      (bricky),
    .health      (health),
    .ready       (ready),
    .bricks_left (bricks_left),
    .all_clear   (all_clear),
    .erase_valid (erase_valid),
    .erase_x     (erase_x),
    .erase_y     (erase_y),
    .erase_ack   (erase_ack),
    .erase_ovf   (erase_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int c, input int r);
    memx = 10'(c * 20);
    memy = 10'(r * 10);
  endtask

  // Bounded wait for ready; returns the number of edges taken (100 if it never came).
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 100);
  endtask

  task automatic kill(input int c, input int r);
    at(c, r);
    game_write  = 1'b1;
    game_health = 2'd0;
    step();
    game_write  = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_all_clear"}, 32'(all_clear), 0);
    chk({tag, "_health"}, 32'(health), 0);
    chk({tag, "_brickx"}, 32'(brickx), 0);
    chk({tag, "_bricky"}, 32'(bricky), 0);
    chk({tag, "_bricks_left"}, 32'(bricks_left), 0);
    chk({tag, "_erase_valid"}, 32'(erase_valid), 0);
    chk({tag, "_erase_x"}, 32'(erase_x), 0);
    chk({tag, "_erase_y"}, 32'(erase_y), 0);
    chk({tag, "_erase_ovf"}, 32'(erase_ovf), 0);
  endtask

  initial begin
    // Power-on reset, asserted before the first clock edge.
    #2 resetn = 1'b0;
    #1 reset_vals("por");
    step();
    step();
    resetn = 1'b1;
    wait_ready(ncyc);
    chk("init_cycles", 32'(ncyc), 32);
    chk("init_bricks_left", 32'(bricks_left), 32);
    chk("init_all_clear", 32'(all_clear), 0);
    chk("init_erase_valid", 32'(erase_valid), 0);

    // Every cell reads back INIT_HEALTH with its aligned origin.
    for (int i = 0; i < 32; i++) begin
      at(i % 8, i / 8);
      step();
      chk($sformatf("read_h_%0d", i), 32'(health), 3);
      chk($sformatf("read_x_%0d", i), 32'(brickx), 32'((i % 8) * 20));
      chk($sformatf("read_y_%0d", i), 32'(bricky), 32'((i / 8) * 10));
    end

    // Unaligned address inside cell (2,1).
    memx = 10'd45; memy = 10'd17;
    step();
    chk("unal_x", 32'(brickx), 40);
    chk("unal_y", 32'(bricky), 10);
    chk("unal_h", 32'(health), 3);
    // Row 4 is below the grid: health 0, coordinates still aligned.
    memy = 10'd40;
    step();
    chk("oog_h", 32'(health), 0);
    chk("oog_x", 32'(brickx), 40);
    chk("oog_y", 32'(bricky), 40);
    memx = 10'd1000; memy = 10'd5;
    step();
    chk("oog2_h", 32'(health), 0);
    chk("oog2_x", 32'(brickx), 1000);
    chk("oog2_y", 32'(bricky), 0);

    // Wear cell (0,0) down 2 -> 1 -> 0.
    at(0, 0);
    game_write = 1'b1;
    game_health = 2'd2; step(); chk("w00_h2", 32'(health), 2);
    chk("w00_bl_2", 32'(bricks_left), 32);
    game_health = 2'd1; step(); chk("w00_h1", 32'(health), 1);
    game_health = 2'd0; step(); chk("w00_h0", 32'(health), 0);
    game_write = 1'b0;
    chk("w00_bl", 32'(bricks_left), 31);
    chk("w00_ev", 32'(erase_valid), 1);
    chk("w00_ex", 32'(erase_x), 0);
    chk("w00_ey", 32'(erase_y), 0);
    // Zero onto a dead cell is ignored.
    game_write = 1'b1; game_health = 2'd0; step(); game_write = 1'b0;
    chk("dead_bl", 32'(bricks_left), 31);
    chk("dead_ovf", 32'(erase_ovf), 0);
    step();
    chk("dead_ev", 32'(erase_valid), 1);
    chk("dead_ex", 32'(erase_x), 0);
    // Raising health is ignored: cell (1,0) at 1, write 3.
    at(1, 0);
    game_write = 1'b1; game_health = 2'd1; step(); chk("up_h1", 32'(health), 1);
    game_health = 2'd3; step(); chk("up_h3_bypass", 32'(health), 1);
    game_write = 1'b0; step(); chk("up_h3_stored", 32'(health), 1);
    // Equal-value write is also ignored.
    game_write = 1'b1; game_health = 2'd1; step(); game_write = 1'b0;
    step(); chk("eq_h", 32'(health), 1);
    chk("eq_bl", 32'(bricks_left), 31);
    erase_ack = 1'b1; step(); erase_ack = 1'b0;
    chk("pop0_ev", 32'(erase_valid), 0);

    // Three kills with no ack: two queue, third overflows.
    kill(2, 0);
    chk("q1_ev", 32'(erase_valid), 1);
    chk("q1_ex", 32'(erase_x), 40);
    chk("q1_bl", 32'(bricks_left), 30);
    kill(3, 0);
    chk("q2_ex", 32'(erase_x), 40);
    chk("q2_ovf", 32'(erase_ovf), 0);
    chk("q2_bl", 32'(bricks_left), 29);
    kill(4, 0);
    chk("q3_ovf", 32'(erase_ovf), 1);
    chk("q3_ex", 32'(erase_x), 40);
    chk("q3_bl", 32'(bricks_left), 28);
    erase_ack = 1'b1;
    step(); chk("pop1_ev", 32'(erase_valid), 1); chk("pop1_ex", 32'(erase_x), 60);
    step(); chk("pop2_ev", 32'(erase_valid), 0);
    step(); chk("pop_empty_ev", 32'(erase_valid), 0);
    erase_ack = 1'b0;
    chk("pop_ovf_sticky", 32'(erase_ovf), 1);

    // Full queue with a simultaneous pop accepts the push.
    kill(5, 0);
    chk("f1_ex", 32'(erase_x), 100);
    kill(6, 0);
    at(7, 0);
    game_write = 1'b1; game_health = 2'd0; erase_ack = 1'b1;
    step();
    game_write = 1'b0;
    chk("sim_ev", 32'(erase_valid), 1);
    chk("sim_ex", 32'(erase_x), 120);
    chk("sim_bl", 32'(bricks_left), 25);
    step(); chk("sim_pop_ex", 32'(erase_x), 140); chk("sim_pop_ey", 32'(erase_y), 0);
    step(); chk("sim_pop_ev", 32'(erase_valid), 0);
    erase_ack = 1'b0;

    // Write-first: cell (0,1) at 2, write 1 with lookup in the same cycle.
    at(0, 1);
    game_write = 1'b1; game_health = 2'd2; step(); chk("wf_h2", 32'(health), 2);
    game_health = 2'd1; step(); chk("wf_h1", 32'(health), 1);
    game_write = 1'b0; step(); chk("wf_stored", 32'(health), 1);
    chk("wf_ey", 32'(bricky), 10);

    // Reset mid-run, then again at init index 10.
    resetn = 1'b0;
    #1 reset_vals("rst_run");
    step();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mid_init_ready", 32'(ready), 0);
    resetn = 1'b0;
    #1 reset_vals("rst_init");
    step();
    resetn = 1'b1;
    wait_ready(ncyc);
    chk("reinit_cycles", 32'(ncyc), 32);
    chk("reinit_bl", 32'(bricks_left), 32);
    at(0, 0); step(); chk("reinit_h00", 32'(health), 3);

    // Destroy every cell.
    for (int i = 0; i < 31; i++) kill(i % 8, i / 8);
    chk("last1_bl", 32'(bricks_left), 1);
    chk("last1_ac", 32'(all_clear), 0);
    kill(7, 3);
    chk("clear_bl", 32'(bricks_left), 0);
    chk("clear_ac", 32'(all_clear), 1);
    chk("clear_ovf", 32'(erase_ovf), 1);
    chk("clear_ex", 32'(erase_x), 0);
    kill(7, 3);
    chk("nowrap_bl", 32'(bricks_left), 0);
    chk("nowrap_ac", 32'(all_clear), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brick_memory.md
BRICK_MEMORY -- requirements
Module: brick_memory

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- BRICKX, 20, brick width in pixels
- BRICKY, 10, brick height in pixels
- COLS, 8, grid columns
- ROWS, 4, grid rows
- INIT_HEALTH, 3, health loaded into every cell at init
REQ-002 clk  in  1  the single clock; all state SHALL change on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 memx, memy  in  10 each  pixel address of the lookup/write target.
REQ-005 game_write  in  1  one-cycle write strobe targeting the cell at memx/memy.
REQ-006 game_health  in  2  new health value for the write.
REQ-007 brickx, bricky  out  10 each  top-left pixel of the cell addressed on the previous cycle.
REQ-008 health  out  2  health of the cell addressed on the previous cycle.
REQ-009 ready  out  1  high when init is complete and lookups are valid.
REQ-010 bricks_left  out  6  count of cells with nonzero health.
REQ-011 all_clear  out  1  high when ready and bricks_left==0.
REQ-012 erase_valid  out  1; erase_x, erase_y  out  10 each  destroyed-brick notification to the renderer.
REQ-013 erase_ack  in  1  renderer accepts the head erase entry.
REQ-014 erase_ovf  out  1  sticky flag set when an erase entry is dropped.

Function
REQ-015 Storage SHALL be ROWS*COLS cells of 2-bit health, indexed by col=memx/BRICKX and row=memy/BRICKY.
REQ-016 An address SHALL be in-grid iff memx < COLS*BRICKX and memy < ROWS*BRICKY.
REQ-017 The FSM SHALL have two states, S_INIT and S_RUN, and SHALL enter S_INIT on reset.
REQ-018 In S_INIT, one cell per cycle SHALL be written with INIT_HEALTH in index order 0..ROWS*COLS-1. After the last cell the FSM SHALL go to S_RUN with bricks_left=ROWS*COLS. ready SHALL be 0 in S_INIT and 1 in S_RUN.
REQ-019 Read latency SHALL be 1 cycle. On each edge in S_RUN, the outputs SHALL register:
- brickx = col*BRICKX, bricky = row*BRICKY
- health = cell value
REQ-020 For an out-of-grid address, health SHALL read 0. brickx/bricky SHALL still report the aligned coordinates.
REQ-021 A write SHALL be accepted only in S_RUN, to an in-grid cell, with game_health strictly less than the current value. All other writes SHALL be ignored without side effects.
REQ-022 An accepted write SHALL update the cell at the same edge.
REQ-023 A lookup and a write to the same cell in the same cycle SHALL return the new value (write-first).
REQ-024 An accepted write taking a cell from nonzero to 0 SHALL:
- decrement bricks_left by 1
- push (col*BRICKX, row*BRICKY) into a 2-entry FIFO
REQ-025 erase_valid SHALL be high whenever the FIFO is non-empty, with erase_x/erase_y showing the head entry. Data SHALL hold stable until an edge with erase_valid && erase_ack pops the entry.
REQ-026 A push into a full FIFO SHALL be dropped and SHALL set erase_ovf. An edge with a simultaneous pop SHALL accept the push. erase_ovf SHALL clear only on reset.
REQ-027 erase_ack while the FIFO is empty SHALL be ignored.
REQ-028 bricks_left SHALL never wrap below 0.
REQ-029 Address arithmetic SHALL be unsigned 10-bit. Division SHALL be by constant BRICKX/BRICKY, truncating.

Reset
REQ-030 resetn low SHALL immediately set the following, and the FSM SHALL restart at S_INIT even mid-init or mid-run:
- ready=0, all_clear=0
- health=0, brickx=0, bricky=0
- bricks_left=0
- erase_valid=0, erase_x=0, erase_y=0, erase_ovf=0
- FIFO empty, init index=0
REQ-031 After resetn rises, ready SHALL assert exactly ROWS*COLS cycles later (32 with defaults).

Verification
REQ-032 Release reset, count cycles -> ready rises after 32 cycles, bricks_left=32. Reads of every cell then return health=3.
REQ-033 Address memx=45, memy=17 -> next cycle brickx=40, bricky=10, health=3. memy=40 -> health=0.
REQ-034 Write game_health=2, then 1, then 0 to cell (0,0):
- bricks_left=31 after the third write
- erase_valid=1 with erase_x=0, erase_y=0
- a further write of 0 is ignored
- a write of 3 to a cell at 1 is ignored
REQ-035 Destroy 3 bricks with erase_ack=0:
- first two are queued
- third sets erase_ovf
- bricks_left still decrements to 29
- acks pop the queue in order
REQ-036 Same-cycle write (game_health=1) and lookup of a cell at 2 -> next cycle health=1.
REQ-037 Cover both reset cases:
- assert resetn at init index 10 -> ready stays low a full 32 cycles after release
- destroy all 32 cells -> all_clear=1
